// File: rtl/arm_mem_sys.sv
// arm_mem_sys: word RAM plus memory-mapped TX FIFO and compare timer behind the multicycle ARM core bus
module arm_mem_sys #(
   parameter int RAM_WORDS = 64,
   parameter int FIFO_DEPTH = 8,
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemWrite,
   input  logic [31:0] Adr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        tx_ready,
   output logic        irq
);
   localparam int AW = $clog2(RAM_WORDS);
   localparam int PW = $clog2(FIFO_DEPTH);
   logic [31:0]   ram [RAM_WORDS];
   logic [7:0]    fifo [FIFO_DEPTH];
   logic [PW-1:0] rptr, wptr;
   logic [CW-1:0] count;
   logic          overflow;
   logic [31:0]   timer, cmp, status;
   logic [15:0]   off;
   logic          periph, wr_tx, wr_st, wr_tmr, wr_cmp, full, empty, pop, push;
   assign periph   = Adr[31:16] == 16'hFFFF;
   assign off      = Adr[15:0];
   assign wr_tx    = MemWrite && periph && off == 16'h0000;
   assign wr_st    = MemWrite && periph && off == 16'h0004;
   assign wr_tmr   = MemWrite && periph && off == 16'h0008;
   assign wr_cmp   = MemWrite && periph && off == 16'h000C;
   assign empty    = count == '0;
   assign full     = count == CW'(FIFO_DEPTH);
   assign tx_valid = !empty;
   assign pop      = tx_valid && tx_ready;
   // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
   assign push     = wr_tx && (!full || pop);
   assign tx_data  = tx_valid ? fifo[rptr] : 8'h00;
   assign status   = {{(24 - CW){1'b0}}, count, 5'b0, overflow, full, empty};
   assign ReadData = !periph ? ram[Adr[2 +: AW]] :
                     off == 16'h0004 ? status :
                     off == 16'h0008 ? timer :
                     off == 16'h000C ? cmp : 32'h0;
   // storage arrays: not cleared by reset, but reset still blocks writes
   always_ff @(posedge clk) begin
      if (!reset && MemWrite && !periph) ram[Adr[2 +: AW]] <= WriteData;
      if (!reset && push) fifo[wptr] <= WriteData[7:0];
   end
   // FIFO control, timer, compare register and sticky interrupt
   always_ff @(posedge clk) begin
      if (reset) begin
         rptr     <= '0;
         wptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         timer    <= '0;
         cmp      <= '1;
         irq      <= 1'b0;
      end else begin
         if (pop) rptr <= rptr + PW'(1);
         if (push) wptr <= wptr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (wr_tx && full && !pop) overflow <= 1'b1;
         else if (wr_st && WriteData[2]) overflow <= 1'b0;
         timer <= wr_tmr ? WriteData : timer + 32'd1;
         if (wr_cmp) cmp <= WriteData;
         irq <= !wr_cmp && (irq || timer == cmp);
      end
   end
endmodule

// File: tb/tb_arm_mem_sys.sv
// tb_arm_mem_sys: randomized and directed checks of arm_mem_sys against a queue-based model
module tb_arm_mem_sys;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        MemWrite = 1'b0;
   logic [31:0] Adr = '0;
   logic [31:0] WriteData = '0;
   logic        tx_ready = 1'b0;
   logic [31:0] ReadData;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        irq;
   int          vectors = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;
   logic [7:0]  q[$];
   logic [31:0] m_ram [64];
   bit          m_known [64];
   bit          m_ovf, m_irq;
   logic [31:0] m_tmr, m_cmp;
   logic [7:0]  exp_bytes [8];

   arm_mem_sys dut (
      .clk(clk), .reset(reset), .MemWrite(MemWrite), .Adr(Adr), .WriteData(WriteData),
      .ReadData(ReadData), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_rd();
      logic [15:0] o;
      o = Adr[15:0];
      if (Adr[31:16] != 16'hFFFF) return m_ram[Adr[7:2]];
      if (o == 16'h0004)
         return (32'(q.size()) << 8) | (32'(m_ovf) << 2) | (32'(q.size() == 8) << 1) | 32'(q.size() == 0);
      if (o == 16'h0008) return m_tmr;
      if (o == 16'h000C) return m_cmp;
      return 32'h0;
   endfunction

   // reference model: FIFO as a queue, registers as plain variables
   always @(posedge clk) begin
      bit pop, full0, match, per;
      logic [15:0] o;
      per = Adr[31:16] == 16'hFFFF;
      o = Adr[15:0];
      if (reset) begin
         q.delete();
         m_ovf = 1'b0;
         m_tmr = '0;
         m_cmp = '1;
         m_irq = 1'b0;
      end else begin
         pop = q.size() != 0 && tx_ready;
         full0 = q.size() == 8;
         match = m_tmr == m_cmp;
         if (pop) void'(q.pop_front());
         m_tmr = m_tmr + 32'd1;
         if (match) m_irq = 1'b1;
         if (MemWrite) begin
            if (!per) begin
               m_ram[Adr[7:2]] = WriteData;
               m_known[Adr[7:2]] = 1'b1;
            end else if (o == 16'h0000) begin
               if (!full0 || pop) q.push_back(WriteData[7:0]);
               else m_ovf = 1'b1;
            end else if (o == 16'h0004) begin
               if (WriteData[2]) m_ovf = 1'b0;
            end else if (o == 16'h0008) m_tmr = WriteData;
            else if (o == 16'h000C) begin
               m_cmp = WriteData;
               m_irq = 1'b0;
            end
         end
      end
   end

   // every-cycle comparison of all outputs against the model
   always @(negedge clk) begin
      if (chk_en) begin
         check("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
         check("tx_data", 32'(tx_data), q.size() != 0 ? {24'h0, q[0]} : 32'h0);
         check("irq", 32'(irq), 32'(m_irq));
         if (Adr[31:16] == 16'hFFFF || m_known[Adr[7:2]]) check("ReadData", ReadData, exp_rd());
      end
   end

   task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
      MemWrite = we;
      Adr = a;
      WriteData = d;
      tx_ready = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
      MemWrite = 1'b0;
      Adr = a;
      tx_ready = 1'b0;
      @(negedge clk);
      check(nm, ReadData, exp);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string nm);
      MemWrite = 1'b0;
      Adr = 32'hFFFF_0004;
      tx_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check(nm, 32'(tx_data), 32'(exp_bytes[i]));
         @(posedge clk);
         #1;
      end
      tx_ready = 1'b0;
   endtask

   initial begin
      int n;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      rd("timer_after_reset", 32'hFFFF_0008, 32'h0);
      rd("status_reset", 32'hFFFF_0004, 32'h1);
      rd("cmp_reset", 32'hFFFF_000C, 32'hFFFF_FFFF);
      check("txvalid_reset", 32'(tx_valid), 32'h0);
      // RAM write, read and alias
      step(1'b1, 32'h40, 32'h1234_5678, 1'b0);
      rd("ram_0x40", 32'h40, 32'h1234_5678);
      rd("ram_alias_0x140", 32'h140, 32'h1234_5678);
      // fill past full, then drain in order
      for (int i = 1; i <= 9; i++) step(1'b1, 32'hFFFF_0000, 32'(i), 1'b0);
      rd("status_full_ovf", 32'hFFFF_0004, 32'h0000_0806);
      for (int i = 0; i < 8; i++) exp_bytes[i] = 8'(i + 1);
      drain("drain_1_8");
      @(negedge clk);
      check("txvalid_drained", 32'(tx_valid), 32'h0);
      check("status_empty_ovf", ReadData, 32'h5);
      @(posedge clk);
      #1;
      step(1'b1, 32'hFFFF_0004, 32'h4, 1'b0);
      rd("status_ovf_clear", 32'hFFFF_0004, 32'h1);
      // push and pop together while full
      for (int i = 0; i < 8; i++) step(1'b1, 32'hFFFF_0000, 32'h10 + 32'(i), 1'b0);
      MemWrite = 1'b1;
      Adr = 32'hFFFF_0000;
      WriteData = 32'hAA;
      tx_ready = 1'b1;
      @(negedge clk);
      check("head_before_pushpop", 32'(tx_data), 32'h10);
      @(posedge clk);
      #1;
      rd("status_full_noovf", 32'hFFFF_0004, 32'h0000_0802);
      for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h11 + 8'(i);
      exp_bytes[7] = 8'hAA;
      drain("drain_aa_last");
      // timer wrap
      step(1'b1, 32'hFFFF_0008, 32'hFFFF_FFFE, 1'b0);
      rd("timer_fffffffe", 32'hFFFF_0008, 32'hFFFF_FFFE);
      rd("timer_ffffffff", 32'hFFFF_0008, 32'hFFFF_FFFF);
      rd("timer_wrap0", 32'hFFFF_0008, 32'h0);
      check("irq_at_wrap_match", 32'(irq), 32'h1);
      // compare interrupt: irq first seen in the cycle the timer reads 21
      step(1'b1, 32'hFFFF_000C, 32'd20, 1'b0);
      step(1'b1, 32'hFFFF_0008, 32'd10, 1'b0);
      MemWrite = 1'b0;
      Adr = 32'hFFFF_0008;
      n = 0;
      for (int i = 0; i < 20 && n == 0; i++) begin
         @(negedge clk);
         if (irq) begin
            n = 1;
            check("timer_when_irq_rises", ReadData, 32'd21);
         end
         @(posedge clk);
         #1;
      end
      if (n == 0) check("irq_rise_timeout", 32'(irq), 32'h1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("irq_sticky", 32'(irq), 32'h1);
         @(posedge clk);
         #1;
      end
      step(1'b1, 32'hFFFF_000C, 32'h100, 1'b0);
      @(negedge clk);
      check("irq_cleared_by_cmp", 32'(irq), 32'h0);
      @(posedge clk);
      #1;
      // reset in the middle of activity
      step(1'b1, 32'h80, 32'hCAFE_F00D, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 32'hFFFF_0000, 32'h30 + 32'(i), 1'b0);
      step(1'b1, 32'hFFFF_0008, 32'h100, 1'b0);
      step(1'b0, 32'hFFFF_0004, 32'h0, 1'b0);
      check("irq_before_reset", 32'(irq), 32'h1);
      check("status_3_bytes", ReadData, 32'h0000_0300);
      reset = 1'b1;
      step(1'b1, 32'hFFFF_0000, 32'h55, 1'b0);
      reset = 1'b0;
      rd("timer_post_reset0", 32'hFFFF_0008, 32'h0);
      rd("timer_post_reset1", 32'hFFFF_0008, 32'h1);
      rd("status_post_reset", 32'hFFFF_0004, 32'h1);
      rd("cmp_post_reset", 32'hFFFF_000C, 32'hFFFF_FFFF);
      check("irq_post_reset", 32'(irq), 32'h0);
      check("txvalid_post_reset", 32'(tx_valid), 32'h0);
      rd("ram_kept_0x80", 32'h80, 32'hCAFE_F00D);
      rd("ram_kept_0x40", 32'h40, 32'h1234_5678);
      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         int k;
         k = int'($urandom_range(0, 6));
         reset = $urandom_range(0, 99) == 0;
         tx_ready = $urandom_range(0, 3) == 0;
         MemWrite = $urandom_range(0, 1) == 1;
         WriteData = $urandom;
         case (k)
            0, 1: Adr = $urandom & 32'h7FFF_FFFF;
            2: Adr = 32'hFFFF_0000;
            3: Adr = 32'hFFFF_0004;
            4: Adr = 32'hFFFF_0008;
            5: begin
               Adr = 32'hFFFF_000C;
               WriteData = m_tmr + 32'($urandom_range(1, 6));
            end
            default: Adr = 32'hFFFF_0010 + ($urandom & 32'h0000_FFE0);
         endcase
         @(posedge clk);
         #1;
      end
      reset = 1'b0;
      MemWrite = 1'b0;
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
